dmpresent_arbiter: RTL and testbench
====================================

Name: dmpresent_arbiter

Overview:
- Shares one DMPRESENT block-cipher core (64-bit block, 80-bit key, load/done handshake) between two requesters.
- Round-robin grant, operand capture, one-cycle load pulse to the core, completion detection, result return, and a watchdog that resets the core on a hang.
- Sits between two bus wrappers/DMA clients and a single core instance.

Parameters:
- TIMEOUT, 64, max cycles in WAIT before abort (≥4)
- CNT_W, 7, watchdog counter width; must hold TIMEOUT

Ports:
- clk  in  1  clock, all logic on rising edge
- iReset_n  in  1  asynchronous active-low reset
- req0  in  1  requester 0 request, level; held until gnt0
- key0  in  80  requester 0 key, stable while req0=1
- dat0  in  64  requester 0 plaintext, stable while req0=1
- gnt0  out  1  one-cycle pulse: operands of req0 captured
- req1 / key1 / dat1 / gnt1  same as requester 0
- rsp_valid  out  1  one-cycle pulse: result or error available
- rsp_id  out  1  requester owning the response
- rsp_err  out  1  1 = watchdog abort, rsp_dat invalid
- rsp_dat  out  64  ciphertext, held until next rsp_valid
- busy  out  1  1 in any state other than IDLE
- core_reset_n  out  1  to core iReset_n
- core_load  out  1  to core load, one-cycle pulse
- core_key  out  80  to core key, registered
- core_dat  out  64  to core idat, registered
- core_odat  in  64  from core odat
- core_done  in  1  from core done

Behaviour:
- Reset (async, iReset_n=0): state=IDLE; gnt0/gnt1/rsp_valid/rsp_id/rsp_err/core_load=0; rsp_dat, core_key, core_dat=0; busy=0; core_reset_n=0; rr pointer=0 (requester 0 preferred next). core_reset_n returns to 1 on the first clock after release.
- States: IDLE, LOAD, WAIT, RESP, ABORT.
- IDLE
  - If only one req is high, grant it. If both are high, grant the one the rr pointer prefers.
  - On grant: capture key/dat into core_key/core_dat, record owner, pulse gntN for one cycle, go to LOAD.
  - Flip the rr pointer to prefer the other requester after every grant.
- LOAD: core_load=1 for exactly this one cycle; clear the done_seen_low flag; clear the watchdog; go to WAIT.
- WAIT
  - done_seen_low is set once core_done=0 has been sampled. This rejects a stale done left from the previous operation.
  - If core_done=1 and done_seen_low=1: capture core_odat into rsp_dat and go to RESP.
  - Otherwise increment the watchdog. When it reaches TIMEOUT-1 with no valid completion, go to ABORT.
  - If completion and timeout occur in the same cycle, completion wins.
- RESP: rsp_valid=1, rsp_id=owner, rsp_err=0 for one cycle; go to IDLE.
- ABORT: core_reset_n=0 for one cycle; rsp_valid=1, rsp_id=owner, rsp_err=1; rsp_dat unchanged; go to IDLE.
- Request handling:
  - req is ignored outside IDLE. A requester may deassert req before its gnt; that request is dropped without side effect.
  - After gnt, a requester may change key/dat freely; the captured copy is used.
- Throughput: a new grant is possible on the cycle after RESP/ABORT (IDLE evaluates that cycle). Minimum latency from gnt to rsp_valid = 3 + core compute cycles.
- busy=0 only in IDLE.
- core_load never asserts in the same cycle as core_reset_n=0.
- rsp_err resets to 0 on the next rsp_valid without error.
- Fairness: with both requesters permanently requesting, grants strictly alternate 0,1,0,1…

Test Plan:
- Single op: req0 with key=80'h0, dat=64'h0; core model done after 32 cycles → gnt0 at cycle 1, core_load one cycle later, rsp_valid with rsp_id=0, rsp_err=0, rsp_dat=core_odat (64'h5579C1387B228445 for real core).
- Contention: req0 and req1 both high from reset → gnt0 first, then gnt1 on the cycle after the first RESP. Hold both for 4 ops → grant order 0,1,0,1.
- Stale done: core model holds done=1 from the previous op for 2 cycles after load → no early response; rsp_valid only after done falls and rises again.
- Timeout: core model never asserts done, TIMEOUT=64 → ABORT entered TIMEOUT cycles after entry to WAIT; core_reset_n low one cycle; rsp_valid with rsp_err=1 and correct rsp_id; a subsequent req1 completes normally with rsp_err=0.
- Reset mid-op: assert iReset_n=0 while in WAIT → all outputs take reset values immediately; no rsp_valid after release; the rr pointer prefers requester 0.
- Operand capture: change key0/dat0 on the cycle after gnt0 → core_key/core_dat keep the captured values until the next grant.

Source files
------------

// File: rtl/dmpresent_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the shared
// DMPRESENT core. The arbiter sits on the slave modport; requesters and
// the core model sit on the master modport.
//
// Handshake: reqN is a level request with keyN/datN held stable while it
// is high. gntN is a one-cycle pulse meaning "operands captured", after
// which the requester may drop reqN and change its operands freely.
// rsp_valid is a one-cycle pulse with no back-pressure; rsp_id names the
// owner, and rsp_err=1 marks a watchdog abort (rsp_dat then not updated).
interface dmpresent_arbiter_if;
  logic        req0;
  logic [79:0] key0;
  logic [63:0] dat0;
  logic        gnt0;
  logic        req1;
  logic [79:0] key1;
  logic [63:0] dat1;
  logic        gnt1;
  logic        rsp_valid;
  logic        rsp_id;
  logic        rsp_err;
  logic [63:0] rsp_dat;
  logic        busy;
  logic        core_reset_n;
  logic        core_load;
  logic [79:0] core_key;
  logic [63:0] core_dat;
  logic [63:0] core_odat;
  logic        core_done;

  modport slave (
    input  req0, key0, dat0, req1, key1, dat1, core_odat, core_done,
    output gnt0, gnt1, rsp_valid, rsp_id, rsp_err, rsp_dat, busy,
           core_reset_n, core_load, core_key, core_dat
  );

  modport master (
    output req0, key0, dat0, req1, key1, dat1, core_odat, core_done,
    input  gnt0, gnt1, rsp_valid, rsp_id, rsp_err, rsp_dat, busy,
           core_reset_n, core_load, core_key, core_dat
  );
endinterface

// File: rtl/dmpresent_arbiter.sv
// Two-requester round-robin front end for one DMPRESENT cipher core.
// Captures the winner's operands, pulses the core load, waits for a fresh
// done (a done left over from the previous operation is ignored until done
// has been seen low), returns the result, and resets the core through a
// watchdog abort if no completion arrives in time.
module dmpresent_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic                 clk,
  input  logic                 iReset_n,
  dmpresent_arbiter_if.slave   bus,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    ABORT = 3'd4
  } state_t;

  state_t             state;
  logic               rr;            // 0: requester 0 preferred on a tie
  logic               owner;         // requester whose operation is in flight
  logic               done_seen_low; // core_done sampled low since the load
  logic [CNT_W-1:0]   wd;            // watchdog cycles spent in WAIT

  assign dbg_state = state;

  // busy decodes straight from the state register
  assign bus.busy = (state != IDLE);

  // Single FSM: grant, load pulse, completion/watchdog, response; all outputs registered
  always_ff @(posedge clk or negedge iReset_n) begin
    if (!iReset_n) begin
      state            <= IDLE;
      rr               <= 1'b0;
      owner            <= 1'b0;
      done_seen_low    <= 1'b0;
      wd               <= '0;
      bus.gnt0         <= 1'b0;
      bus.gnt1         <= 1'b0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_id       <= 1'b0;
      bus.rsp_err      <= 1'b0;
      bus.rsp_dat      <= '0;
      bus.core_reset_n <= 1'b0;
      bus.core_load    <= 1'b0;
      bus.core_key     <= '0;
      bus.core_dat     <= '0;
    end else begin
      // pulses default low; core reset released unless an abort drives it
      bus.gnt0         <= 1'b0;
      bus.gnt1         <= 1'b0;
      bus.rsp_valid    <= 1'b0;
      bus.core_load    <= 1'b0;
      bus.core_reset_n <= 1'b1;

      case (state)
        IDLE: begin
          if (bus.req0 && (!bus.req1 || !rr)) begin
            bus.core_key <= bus.key0;
            bus.core_dat <= bus.dat0;
            owner        <= 1'b0;
            bus.gnt0     <= 1'b1;
            rr           <= 1'b1;
            state        <= LOAD;
          end else if (bus.req1) begin
            bus.core_key <= bus.key1;
            bus.core_dat <= bus.dat1;
            owner        <= 1'b1;
            bus.gnt1     <= 1'b1;
            rr           <= 1'b0;
            state        <= LOAD;
          end
        end

        LOAD: begin
          // load pulse lands in the first WAIT cycle, never during an abort
          bus.core_load <= 1'b1;
          done_seen_low <= 1'b0;
          wd            <= '0;
          state         <= WAIT;
        end

        WAIT: begin
          if (bus.core_done && done_seen_low) begin
            // completion takes priority over a simultaneous timeout
            bus.rsp_dat   <= bus.core_odat;
            bus.rsp_valid <= 1'b1;
            bus.rsp_id    <= owner;
            bus.rsp_err   <= 1'b0;
            state         <= RESP;
          end else begin
            if (!bus.core_done) begin
              done_seen_low <= 1'b1;
            end
            if (wd == CNT_W'(TIMEOUT - 1)) begin
              bus.core_reset_n <= 1'b0;
              bus.rsp_valid    <= 1'b1;
              bus.rsp_id       <= owner;
              bus.rsp_err      <= 1'b1;
              state            <= ABORT;
            end else begin
              wd <= wd + 1'b1;
            end
          end
        end

        RESP: begin
          state <= IDLE;
        end

        ABORT: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmpresent_arbiter.sv
// Bench for dmpresent_arbiter: behavioural core model, grant/response
// scoreboards, a table of operations and hand-written corner sequences.
module tb_dmpresent_arbiter;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 7;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       iReset_n = 1'b0;
  logic [2:0] dbg_state;
  int         cycle = 0;

  dmpresent_arbiter_if bus();

  dmpresent_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .iReset_n  (iReset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // ---------------- counters / scoreboard ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [65:0] exp_q[$];      // {rsp_id, rsp_err, rsp_dat}
  logic        exp_gnt_q[$];  // requester id expected on each grant
  logic [63:0] last_dat = '0; // rsp_dat the DUT should currently hold
  int          last_gnt_cycle = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stand-in cipher; the arbiter only moves the value around.
  function automatic logic [63:0] cipher(input logic [79:0] k, input logic [63:0] d);
    return {d[31:0], d[63:32]} ^ k[63:0] ^ {48'h0, k[79:64]} ^ 64'h5579C1387B228445;
  endfunction

  function automatic logic [65:0] exp_rsp(input logic id, input logic err,
                                          input logic [79:0] k, input logic [63:0] d);
    if (!err) last_dat = cipher(k, d);
    return {id, err, last_dat};
  endfunction

  // ---------------- core model ----------------
  int          cm_delay = 8;
  bit          cm_stale = 1'b0;
  bit          cm_hang  = 1'b0;
  logic [79:0] m_key;
  logic [63:0] m_dat;
  int          cnt;
  int          hold_cnt;
  bit          running;

  always @(posedge clk or negedge bus.core_reset_n) begin
    if (!bus.core_reset_n) begin
      bus.core_done <= 1'b0;
      bus.core_odat <= '0;
      running       <= 1'b0;
      cnt           <= 0;
      hold_cnt      <= 0;
    end else if (bus.core_load) begin
      m_key         <= bus.core_key;
      m_dat         <= bus.core_dat;
      bus.core_odat <= 64'hDEADBEEF0BADF00D;
      cnt           <= cm_delay;
      running       <= !cm_hang;
      if (cm_stale) begin
        hold_cnt <= 2;
      end else begin
        hold_cnt      <= 0;
        bus.core_done <= 1'b0;
      end
    end else begin
      if (hold_cnt != 0) begin
        hold_cnt <= hold_cnt - 1;
        if (hold_cnt == 1) bus.core_done <= 1'b0;
      end
      if (running) begin
        if (cnt <= 1) begin
          bus.core_done <= 1'b1;
          bus.core_odat <= cipher(m_key, m_dat);
          running       <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  // ---------------- monitor (scoreboard pop side) ----------------
  always @(negedge clk) begin
    if (iReset_n) begin
      if (bus.gnt0 || bus.gnt1) begin
        if (exp_gnt_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL gnt_unexpected: got gnt1/gnt0=%b%b expected none", bus.gnt1, bus.gnt0);
        end else begin
          logic e;
          e = exp_gnt_q.pop_front();
          check("gnt_id", {bus.gnt1, bus.gnt0}, e ? 2'b10 : 2'b01);
          check("busy_at_gnt", bus.busy, 1'b1);
        end
        last_gnt_cycle = cycle;
      end
      if (bus.core_load) check("load_with_core_reset", bus.core_reset_n, 1'b1);
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rsp_unexpected: got id=%b err=%b dat=%h expected none",
                   bus.rsp_id, bus.rsp_err, bus.rsp_dat);
        end else begin
          logic [65:0] e;
          e = exp_q.pop_front();
          check("rsp", {bus.rsp_id, bus.rsp_err, bus.rsp_dat}, e);
          check("core_reset_n_at_rsp", bus.core_reset_n, !e[64]);
          if (e[64]) check("abort_latency", cycle - last_gnt_cycle, TIMEOUT + 1);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_until_done(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || bus.req0 || bus.req1) && n < budget) begin
      @(negedge clk);
      n++;
      if (bus.gnt0) begin
        bus.req0 = 1'b0;
        bus.key0 = ~bus.key0;
        bus.dat0 = ~bus.dat0;
      end
      if (bus.gnt1) begin
        bus.req1 = 1'b0;
        bus.key1 = ~bus.key1;
        bus.dat1 = ~bus.dat1;
      end
    end
    if (n >= budget) begin
      n_cmp++; n_bad++;
      $display("FAIL run_timeout: got %0d pending responses after %0d cycles expected 0", exp_q.size(), n);
      exp_q.delete();
      exp_gnt_q.delete();
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
    end
    @(negedge clk);
    check("busy_idle", bus.busy, 1'b0);
  endtask

  task automatic wait_gnt(input logic id, input int budget);
    int n = 0;
    while (!(id ? bus.gnt1 : bus.gnt0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      n_cmp++; n_bad++;
      $display("FAIL gnt_timeout: got no gnt%0d within %0d cycles expected one", id, budget);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  reqs;       // {req1, req0}
    logic [79:0] key0;
    logic [63:0] dat0;
    logic [79:0] key1;
    logic [63:0] dat1;
    int          delay;
    bit          stale;
    bit          hang;
    bit          exp_first;  // requester granted first
    bit          exp_err;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [79:0] ka;
    logic [63:0] da;

    bus.req0 = 1'b0; bus.key0 = '0; bus.dat0 = '0;
    bus.req1 = 1'b0; bus.key1 = '0; bus.dat1 = '0;

    vecs[0] = '{2'b01, 80'h0123456789ABCDEF1357, 64'h0011223344556677, 80'h0, 64'h0, 6, 0, 0, 0, 0};
    vecs[1] = '{2'b10, 80'h0, 64'h0, 80'hFFFF0000FFFF0000AAAA, 64'hCAFEF00D12345678, 10, 0, 0, 1, 0};
    vecs[2] = '{2'b11, 80'h11111111111111111111, 64'h2222222222222222, 80'h33333333333333333333, 64'h4444444444444444, 5, 0, 0, 0, 0};
    vecs[3] = '{2'b11, 80'hA5A5A5A5A5A5A5A5A5A5, 64'h5A5A5A5A5A5A5A5A, 80'h0F0F0F0F0F0F0F0F0F0F, 64'hF0F0F0F0F0F0F0F0, 7, 0, 0, 0, 0};
    vecs[4] = '{2'b01, 80'h00000000000000000001, 64'h8000000000000001, 80'h0, 64'h0, 4, 0, 0, 0, 0};
    vecs[5] = '{2'b11, 80'h13579BDF02468ACE1357, 64'h0F1E2D3C4B5A6978, 80'h2468ACE013579BDF2468, 64'h8796A5B4C3D2E1F0, 9, 0, 0, 1, 0};
    vecs[6] = '{2'b01, 80'hFEDCBA9876543210FEDC, 64'h1234567890ABCDEF, 80'h0, 64'h0, 8, 1, 0, 0, 0};
    vecs[7] = '{2'b10, 80'h0, 64'h0, 80'h99999999999999999999, 64'h7777777777777777, 8, 0, 1, 1, 1};
    vecs[8] = '{2'b10, 80'h0, 64'h0, 80'hABCDEF0123456789ABCD, 64'h3141592653589793, 12, 0, 0, 1, 0};

    // ---- reset state, then single op with req0 already high at release ----
    repeat (3) @(negedge clk);
    check("reset_ctrl", {bus.gnt0, bus.gnt1, bus.rsp_valid, bus.rsp_id, bus.rsp_err,
                         bus.core_load, bus.busy, bus.core_reset_n, dbg_state}, 11'b0);
    check("reset_rsp_dat", bus.rsp_dat, 64'h0);
    check("reset_core_key", bus.core_key, 80'h0);
    check("reset_core_dat", bus.core_dat, 64'h0);

    cm_delay = 32;
    bus.req0 = 1'b1;
    exp_gnt_q.push_back(1'b0);
    exp_q.push_back(exp_rsp(1'b0, 1'b0, 80'h0, 64'h0));
    iReset_n = 1'b1;
    @(negedge clk);
    check("core_reset_release", bus.core_reset_n, 1'b1);
    check("gnt0_first_cycle", bus.gnt0, 1'b1);
    check("load_not_with_gnt", bus.core_load, 1'b0);
    bus.req0 = 1'b0;
    @(negedge clk);
    check("load_after_gnt", {bus.core_load, bus.gnt0}, 2'b10);
    run_until_done(300);

    // ---- table of operations ----
    for (int i = 0; i < 9; i++) begin
      cm_delay = vecs[i].delay;
      cm_stale = vecs[i].stale;
      cm_hang  = vecs[i].hang;
      bus.key0 = vecs[i].key0; bus.dat0 = vecs[i].dat0;
      bus.key1 = vecs[i].key1; bus.dat1 = vecs[i].dat1;
      if (vecs[i].reqs == 2'b11) begin
        exp_gnt_q.push_back(vecs[i].exp_first);
        exp_gnt_q.push_back(!vecs[i].exp_first);
        if (vecs[i].exp_first) begin
          exp_q.push_back(exp_rsp(1'b1, vecs[i].exp_err, vecs[i].key1, vecs[i].dat1));
          exp_q.push_back(exp_rsp(1'b0, vecs[i].exp_err, vecs[i].key0, vecs[i].dat0));
        end else begin
          exp_q.push_back(exp_rsp(1'b0, vecs[i].exp_err, vecs[i].key0, vecs[i].dat0));
          exp_q.push_back(exp_rsp(1'b1, vecs[i].exp_err, vecs[i].key1, vecs[i].dat1));
        end
      end else begin
        exp_gnt_q.push_back(vecs[i].exp_first);
        if (vecs[i].exp_first)
          exp_q.push_back(exp_rsp(1'b1, vecs[i].exp_err, vecs[i].key1, vecs[i].dat1));
        else
          exp_q.push_back(exp_rsp(1'b0, vecs[i].exp_err, vecs[i].key0, vecs[i].dat0));
      end
      bus.req0 = vecs[i].reqs[0];
      bus.req1 = vecs[i].reqs[1];
      run_until_done(300);
    end
    cm_stale = 1'b0;
    cm_hang  = 1'b0;

    // ---- operand capture: change key0/dat0 right after gnt0 ----
    ka = 80'hC0DEC0DEC0DEC0DEC0DE;
    da = 64'h0123456789ABCDEF;
    cm_delay = 10;
    bus.key0 = ka; bus.dat0 = da;
    exp_gnt_q.push_back(1'b0);
    exp_q.push_back(exp_rsp(1'b0, 1'b0, ka, da));
    bus.req0 = 1'b1;
    wait_gnt(1'b0, 20);
    bus.req0 = 1'b0;
    bus.key0 = 80'h5555AAAA5555AAAA5555;
    bus.dat0 = 64'hAAAA5555AAAA5555;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("captured_key_dat", {bus.core_key, bus.core_dat}, {ka, da});
    end
    run_until_done(300);

    // ---- reset in the middle of WAIT (rr points at requester 1 beforehand) ----
    cm_delay = 40;
    bus.key0 = 80'h1; bus.dat0 = 64'h2;
    exp_gnt_q.push_back(1'b0);
    bus.req0 = 1'b1;
    wait_gnt(1'b0, 20);
    bus.req0 = 1'b0;
    repeat (5) @(negedge clk);
    iReset_n = 1'b0;
    #1;
    check("midop_reset_ctrl", {bus.gnt0, bus.gnt1, bus.rsp_valid, bus.rsp_id, bus.rsp_err,
                               bus.core_load, bus.busy, bus.core_reset_n, dbg_state}, 11'b0);
    check("midop_reset_data", {bus.rsp_dat, bus.core_key, bus.core_dat}, 208'h0);
    last_dat = '0;
    repeat (2) @(negedge clk);
    iReset_n = 1'b1;
    repeat (80) @(negedge clk);
    check("no_rsp_after_reset", exp_q.size(), 0);

    cm_delay = 6;
    bus.key0 = 80'hAAAA; bus.dat0 = 64'hBBBB;
    bus.key1 = 80'hCCCC; bus.dat1 = 64'hDDDD;
    exp_gnt_q.push_back(1'b0);
    exp_gnt_q.push_back(1'b1);
    exp_q.push_back(exp_rsp(1'b0, 1'b0, 80'hAAAA, 64'hBBBB));
    exp_q.push_back(exp_rsp(1'b1, 1'b0, 80'hCCCC, 64'hDDDD));
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    run_until_done(300);

    check("exp_gnt_q_empty", exp_gnt_q.size(), 0);
    check("exp_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
